// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter in front of a single memory port: IDLE -> ISSUE -> WAIT -> IDLE.
// Define MEM_ARB_RR_EN for round-robin grant; otherwise LSU has fixed priority over IFU.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ifu_req_valid,
  output logic                o_ifu_req_ready,
  input  logic [ADDR_W-1:0]   i_ifu_addr,
  output logic                o_ifu_rsp_valid,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  output logic                o_ifu_rsp_err,
  input  logic                i_lsu_req_valid,
  output logic                o_lsu_req_ready,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic                i_lsu_wen,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wmask,
  output logic                o_lsu_rsp_valid,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_lsu_rsp_err,
  output logic                o_mem_valid,
  input  logic                i_mem_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_rsp_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           r_state;
  logic             r_owner_lsu;
  logic [CNT_W-1:0] r_cnt;
  logic             w_grant_lsu;
  logic             w_grant_ifu;
  logic             w_timeout;

`ifdef MEM_ARB_RR_EN
  // Set when the LSU wins a tie, i.e. the last accepted request came from the IFU.
  logic r_rr_lsu_fav;
  assign w_grant_lsu = i_lsu_req_valid && (!i_ifu_req_valid || r_rr_lsu_fav);
`else
  assign w_grant_lsu = i_lsu_req_valid;
`endif
  assign w_grant_ifu = i_ifu_req_valid && !w_grant_lsu;

  assign o_lsu_req_ready = (r_state == S_IDLE) && w_grant_lsu;
  assign o_ifu_req_ready = (r_state == S_IDLE) && w_grant_ifu;
  assign o_busy          = (r_state != S_IDLE);

  // r_cnt holds the number of WAIT cycles already elapsed, so this fires in the last allowed one.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign w_timeout = 1'b0;
    end else begin : g_timeout
      assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_owner_lsu     <= 1'b0;
      r_cnt           <= '0;
      o_mem_valid     <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_wen       <= 1'b0;
      o_mem_wdata     <= '0;
      o_mem_wmask     <= '0;
      o_ifu_rsp_valid <= 1'b0;
      o_ifu_rdata     <= '0;
      o_ifu_rsp_err   <= 1'b0;
      o_lsu_rsp_valid <= 1'b0;
      o_lsu_rdata     <= '0;
      o_lsu_rsp_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_rr_lsu_fav    <= 1'b1;
`endif
    end else begin
      o_ifu_rsp_valid <= 1'b0;
      o_ifu_rsp_err   <= 1'b0;
      o_lsu_rsp_valid <= 1'b0;
      o_lsu_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (o_lsu_req_ready) begin
            o_mem_addr  <= i_lsu_addr;
            o_mem_wen   <= i_lsu_wen;
            o_mem_wdata <= i_lsu_wdata;
            o_mem_wmask <= i_lsu_wmask;
            o_mem_valid <= 1'b1;
            r_owner_lsu <= 1'b1;
            r_state     <= S_ISSUE;
`ifdef MEM_ARB_RR_EN
            r_rr_lsu_fav <= 1'b0;
`endif
          end else if (o_ifu_req_ready) begin
            o_mem_addr  <= i_ifu_addr;
            o_mem_wen   <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_wmask <= {MASK_W{1'b1}};
            o_mem_valid <= 1'b1;
            r_owner_lsu <= 1'b0;
            r_state     <= S_ISSUE;
`ifdef MEM_ARB_RR_EN
            r_rr_lsu_fav <= 1'b1;
`endif
          end
        end
        S_ISSUE: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_mem_rsp_valid) begin
            if (r_owner_lsu) begin
              o_lsu_rsp_valid <= 1'b1;
              o_lsu_rdata     <= i_mem_rdata;
            end else begin
              o_ifu_rsp_valid <= 1'b1;
              o_ifu_rdata     <= i_mem_rdata;
            end
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            if (r_owner_lsu) begin
              o_lsu_rsp_valid <= 1'b1;
              o_lsu_rsp_err   <= 1'b1;
              o_lsu_rdata     <= '0;
            end else begin
              o_ifu_rsp_valid <= 1'b1;
              o_ifu_rsp_err   <= 1'b1;
              o_ifu_rdata     <= '0;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: latency, hold-while-stalled, arbitration, timeout, reset, stray strobes.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic        mem_valid, mem_ready, mem_wen, mem_rsp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  bit m_fav_lsu = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ifu_req_valid(ifu_req_valid), .o_ifu_req_ready(ifu_req_ready), .i_ifu_addr(ifu_addr),
    .o_ifu_rsp_valid(ifu_rsp_valid), .o_ifu_rdata(ifu_rdata), .o_ifu_rsp_err(ifu_rsp_err),
    .i_lsu_req_valid(lsu_req_valid), .o_lsu_req_ready(lsu_req_ready), .i_lsu_addr(lsu_addr),
    .i_lsu_wen(lsu_wen), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
    .o_lsu_rsp_valid(lsu_rsp_valid), .o_lsu_rdata(lsu_rdata), .o_lsu_rsp_err(lsu_rsp_err),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask), .i_mem_rsp_valid(mem_rsp_valid),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One complete transaction: handshake, rdy_wait stalled ISSUE cycles, rsp_wait idle WAIT cycles, response.
  task automatic do_txn(input bit lsu, input logic [31:0] addr, input bit wen, input logic [31:0] wd,
                        input logic [3:0] wm, input int rdy_wait, input bit spur, input int rsp_wait,
                        input logic [31:0] rd);
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end
    #1;
    check_eq("req_ready", lsu ? lsu_req_ready : ifu_req_ready, 1);
    check_eq("other_ready", lsu ? ifu_req_ready : lsu_req_ready, 0);
    tick();
    m_fav_lsu = !lsu;
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
    lsu_addr = ~addr; ifu_addr = ~addr; lsu_wdata = ~wd; lsu_wmask = ~wm; lsu_wen = ~wen;
    for (int i = 0; i < rdy_wait; i++) begin
      mem_rsp_valid = spur; mem_rdata = 32'hDEAD_BEEF;
      #1;
      check_eq("issue_valid", mem_valid, 1);
      check_eq("issue_addr", mem_addr, addr);
      check_eq("issue_wen", mem_wen, wen);
      check_eq("issue_wdata", mem_wdata, wd);
      check_eq("issue_wmask", mem_wmask, wm);
      tick();
    end
    mem_rsp_valid = 1'b0; mem_ready = 1'b1;
    #1;
    check_eq("hs_valid", mem_valid, 1);
    check_eq("hs_addr", mem_addr, addr);
    check_eq("hs_busy", busy, 1);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      #1;
      check_eq("wait_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      tick();
    end
    #1;
    check_eq("wait_mem_valid", mem_valid, 0);
    mem_rsp_valid = 1'b1; mem_rdata = rd;
    tick();
    mem_rsp_valid = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    #1;
    check_eq("rsp_valid", lsu ? lsu_rsp_valid : ifu_rsp_valid, 1);
    check_eq("rsp_other", lsu ? ifu_rsp_valid : lsu_rsp_valid, 0);
    check_eq("rsp_rdata", lsu ? lsu_rdata : ifu_rdata, rd);
    check_eq("rsp_err", lsu ? lsu_rsp_err : ifu_rsp_err, 0);
    check_eq("rsp_busy", busy, 0);
    tick();
    check_eq("rsp_single", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    check_eq("rdata_hold", lsu ? lsu_rdata : ifu_rdata, rd);
    $display("txn %s addr=0x%08h wen=%0d rdata=0x%08h", lsu ? "LSU" : "IFU", addr, wen, rd);
  endtask

  task automatic arb_test();
    int  ifu_left = 4;
    int  lsu_left = 4;
    bit  exp_lsu;
    for (int n = 0; n < 8; n++) begin
      ifu_req_valid = (ifu_left > 0); lsu_req_valid = (lsu_left > 0);
      ifu_addr = 32'h1000 + 32'(n * 4); lsu_addr = 32'h2000 + 32'(n * 4); lsu_wen = 1'b0;
      #1;
`ifdef MEM_ARB_RR_EN
      exp_lsu = lsu_req_valid && (!ifu_req_valid || m_fav_lsu);
`else
      exp_lsu = lsu_req_valid;
`endif
      check_eq("arb_lsu_ready", lsu_req_ready, exp_lsu);
      check_eq("arb_ifu_ready", ifu_req_ready, !exp_lsu);
      m_fav_lsu = !exp_lsu;
      if (exp_lsu) lsu_left--; else ifu_left--;
      tick();
      mem_ready = 1'b1;
      #1;
      check_eq("arb_busy_ready", {ifu_req_ready, lsu_req_ready}, 0);
      check_eq("arb_addr", mem_addr, exp_lsu ? 32'h2000 + 32'(n * 4) : 32'h1000 + 32'(n * 4));
      tick();
      mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(n);
      tick();
      mem_rsp_valid = 1'b0;
      check_eq("arb_rsp_lsu", lsu_rsp_valid, exp_lsu);
      check_eq("arb_rsp_ifu", ifu_rsp_valid, !exp_lsu);
      $display("txn arb grant=%s n=%0d", exp_lsu ? "LSU" : "IFU", n);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();
  endtask

  task automatic timeout_test();
    lsu_req_valid = 1'b1; lsu_addr = 32'hC0; lsu_wen = 1'b0;
    tick();
    m_fav_lsu = 1'b0;
    lsu_req_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check_eq("to_early", lsu_rsp_valid, 0);
      tick();
    end
    #1;
    check_eq("to_valid", lsu_rsp_valid, 1);
    check_eq("to_err", lsu_rsp_err, 1);
    check_eq("to_rdata", lsu_rdata, 0);
    check_eq("to_busy", busy, 0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("late_lsu", lsu_rsp_valid, 0);
    check_eq("late_ifu", ifu_rsp_valid, 0);
    check_eq("late_rdata", lsu_rdata, 0);
    $display("txn LSU timeout addr=0x000000c0");
  endtask

  task automatic reset_test();
    ifu_req_valid = 1'b1; ifu_addr = 32'h300;
    tick();
    ifu_req_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    check_eq("rst_ifu_rdata", ifu_rdata, 0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rsp_valid = 1'b0; rst_n = 1'b1; m_fav_lsu = 1'b1;
    tick();
    check_eq("rst_stale_rsp", ifu_rsp_valid, 0);
    $display("txn reset during WAIT");
    do_txn(1'b0, 32'h8000_0010, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1, 32'h0000_0013);
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_mem_valid", mem_valid, 0);
    check_eq("reset_mem_addr", mem_addr, 0);
    check_eq("reset_rsp", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 0, 32'h0000_0413);
    do_txn(1'b1, 32'h0000_00A0, 1'b1, 32'h1234_5678, 4'h3, 4, 1'b0, 0, 32'hCAFE_F00D);
    do_txn(1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'hF, 2, 1'b1, 2, 32'h0102_0304);
    arb_test();
    timeout_test();
    reset_test();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
